// File: rtl/nsa_pkg.sv
// nsa_pkg: shared FSM state encoding and sizing helper for the nibble serial adder
package nsa_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/add4_nibble.sv
// add4_nibble: combinational 4-bit ripple-carry adder
module add4_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add done one nibble per cycle over a valid/ready handshake
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = clog2(NIB);
  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] ra, rb;
  logic [3:0]       ns;
  logic             nc;
  logic             last;
  assign last      = idx == IW'(NIB - 1);
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  add4_nibble u_add (
    .a  (ra[4*idx +: 4]),
    .b  (rb[4*idx +: 4]),
    .ci (carry),
    .s  (ns),
    .co (nc)
  );
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:  state_n = in_valid  ? S_RUN  : S_IDLE;
      S_RUN:   state_n = last      ? S_DONE : S_RUN;
      S_DONE:  state_n = out_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE) begin
        idx <= '0;
        if (in_valid) begin
          ra    <= a;
          rb    <= b;
          carry <= cin;
        end
      end
      if (state == S_RUN) begin
        sum[4*idx +: 4] <= ns;
        carry           <= nc;
        if (last) cout <= nc;
        else idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for the 16-bit nibble serial adder
module tb_nibble_serial_adder;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] a = 0, b = 0;
  logic        cin = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] sum;
  logic        cout;
  int          vectors = 0, miscompares = 0;
  logic [16:0] sb[$];
  always #5 clk = ~clk;
  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                       input int hold, input bit poke);
    int n;
    logic [16:0] e;
    @(negedge clk);
    check("in_ready_pre", 32'(in_ready), 1);
    a = oa; b = ob; cin = oc; in_valid = 1;
    sb.push_back({1'b0, oa} + {1'b0, ob} + 17'(oc));
    @(posedge clk);
    #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (poke && n == 1) begin
        a = ~oa; b = ~ob; cin = ~oc; in_valid = 1;
        check("in_ready_run", 32'(in_ready), 0);
      end
      @(posedge clk);
      #1 n++;
      in_valid = 0;
    end
    check("latency", n, 4);
    if (!out_valid) begin
      void'(sb.pop_front());
      return;
    end
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    e = sb.pop_front();
    check("sum", 32'(sum), 32'(e[15:0]));
    check("cout", 32'(cout), 32'(e[16]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_sum", 32'(sum), 32'(e[15:0]));
      check("hold_cout", 32'(cout), 32'(e[16]));
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("ov_after_hs", 32'(out_valid), 0);
    check("ir_after_hs", 32'(in_ready), 1);
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    do_op(16'h1234, 16'h4321, 0, 0, 0);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0);
    do_op(16'h0000, 16'hFFFF, 1, 0, 0);
    do_op(16'h8000, 16'h8000, 0, 0, 0);
    do_op(16'hABCD, 16'h5432, 1, 5, 1);
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; cin = 0; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(cout), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("abort_no_ov", seen, 0);
    do_op(16'h0F0F, 16'h0101, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), k % 2, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
